// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end that shares one multi-cycle 8-bit
// divider among N_REQ requesters. Trivial cases are answered locally.

// divider_8bit: restoring divider, two cycles per quotient bit.
// Only the quotient bits below the divisor MSB can be non-zero, so the
// partial remainder is preloaded with the top dividend bits. This gives
// 16 - 2m busy cycles for a divisor whose MSB sits at bit m.
module divider_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       strt,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       idle,
    output logic [7:0] quotient,
    output logic [7:0] remainder
);
    typedef enum logic [1:0] {D_IDLE, D_SHIFT, D_SUB} dstate_t;

    dstate_t    dstate;
    logic [8:0] rem_q;
    logic [7:0] dvd_q;
    logic [7:0] dvs_q;
    logic [7:0] quo_q;
    logic [3:0] cnt_q;
    logic [2:0] msb;

    // Bit index of the divisor's most significant one
    always_comb begin
        msb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (divisor[i]) msb = 3'(i);
        end
    end

    // Load on strt, then alternate shift-in and compare/subtract per bit
    always_ff @(posedge clk) begin
        if (rst) begin
            dstate <= D_IDLE;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (dstate)
                D_IDLE: begin
                    if (strt) begin
                        dstate <= D_SHIFT;
                        rem_q  <= {1'b0, dividend >> (4'd8 - {1'b0, msb})};
                        dvd_q  <= dividend << msb;
                        dvs_q  <= divisor;
                        quo_q  <= '0;
                        cnt_q  <= 4'd8 - {1'b0, msb};
                    end
                end
                D_SHIFT: begin
                    rem_q  <= {rem_q[7:0], dvd_q[7]};
                    dvd_q  <= {dvd_q[6:0], 1'b0};
                    dstate <= D_SUB;
                end
                D_SUB: begin
                    if (rem_q >= {1'b0, dvs_q}) begin
                        rem_q <= rem_q - {1'b0, dvs_q};
                        quo_q <= {quo_q[6:0], 1'b1};
                    end else begin
                        quo_q <= {quo_q[6:0], 1'b0};
                    end
                    cnt_q  <= cnt_q - 4'd1;
                    dstate <= (cnt_q == 4'd1) ? D_IDLE : D_SHIFT;
                end
                default: dstate <= D_IDLE;
            endcase
        end
    end

    // Handshake and result outputs
    always_comb begin
        idle      = (dstate == D_IDLE);
        quotient  = quo_q;
        remainder = rem_q[7:0];
    end
endmodule

module divider_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] dividend_in,
    input  logic [8*N_REQ-1:0] divisor_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         quotient,
    output logic [7:0]         remainder,
    output logic               div_err,
    output logic               busy
);
    localparam int IDXW = $clog2(N_REQ);

    typedef enum logic [1:0] {ARB, START, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [IDXW-1:0] last;
    logic [IDXW-1:0] win_idx;
    logic            win_found;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] cand;
    logic [7:0]      win_a;
    logic [7:0]      win_b;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic            err_q;
    logic            local_path;
    logic            local_err;
    logic [7:0]      local_q;
    logic [7:0]      local_r;
    logic            div_strt;
    logic            div_idle;
    logic [7:0]      div_dividend;
    logic [7:0]      div_divisor;
    logic [7:0]      div_quotient;
    logic [7:0]      div_remainder;

    divider_8bit u_div (
        .clk       (clk),
        .rst       (rst),
        .strt      (div_strt),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .idle      (div_idle),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // Round-robin search starting one past the previous winner
    always_comb begin : win_search
        int idx;
        idx       = 0;
        cand      = req & ~mask;
        win_found = 1'b0;
        win_idx   = last;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(idx);
            end
        end
        win_a = dividend_in[8*win_idx +: 8];
        win_b = divisor_in[8*win_idx +: 8];
    end

    // Cases answered without the divider, from the winner's operands
    always_comb begin
        local_path = 1'b1;
        local_err  = 1'b0;
        local_q    = 8'h00;
        local_r    = win_a;
        if (win_b == 8'h00) begin
            local_q   = 8'hFF;
            local_err = 1'b1;
        end else if (win_a < win_b) begin
            local_q = 8'h00;
        end else if (win_b[7]) begin
            local_q = 8'h01;
            local_r = win_a - win_b;
        end else begin
            local_path = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ARB;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ARB:   if (win_found) next_state = local_path ? DONE : START;
            START: next_state = RUN;
            RUN:   if (div_idle) next_state = DONE;
            DONE:  next_state = ARB;
            default: next_state = ARB;
        endcase
    end

    // Outputs decoded from state and held registers
    always_comb begin
        busy         = (state != ARB);
        done         = (state == DONE) ? gnt : '0;
        div_err      = (state == DONE) && err_q;
        div_strt     = (state == START);
        div_dividend = op_a;
        div_divisor  = op_b;
    end

    // Grant, operand latch, result capture and one-cycle mask of the last served
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            last      <= IDXW'(N_REQ - 1);
            mask      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            quotient  <= '0;
            remainder <= '0;
            err_q     <= 1'b0;
        end else begin
            mask <= (state == DONE) ? gnt : '0;
            case (state)
                ARB: begin
                    if (win_found) begin
                        gnt  <= N_REQ'(1) << win_idx;
                        last <= win_idx;
                        op_a <= win_a;
                        op_b <= win_b;
                        if (local_path) begin
                            quotient  <= local_q;
                            remainder <= local_r;
                            err_q     <= local_err;
                        end
                    end
                end
                RUN: begin
                    if (div_idle) begin
                        quotient  <= div_quotient;
                        remainder <= div_remainder;
                        err_q     <= 1'b0;
                    end
                end
                DONE:    gnt <= '0;
                default: ;
            endcase
        end
    end
endmodule
